// File: rtl/alu_result_packer.sv
// Consumer end of the ALU result interface: buffers result records in a small FIFO
// and emits each one as a framed 16-bit word stream (header + payload) with valid/ready.
module alu_result_packer #(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_sel,
  input  logic [15:0]              in_y1,
  input  logic [31:0]              in_y2,
  input  logic [15:0]              in_y3,
  input  logic                     in_cout,
  input  logic                     in_carry_out,
  input  logic                     in_m,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   rec_count,
  output logic                     busy
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int REC_W = 37;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_PAY0 = 2'd2;
  localparam logic [1:0] ST_PAY1 = 2'd3;

  localparam logic [1:0] SEL_Y1    = 2'b00;
  localparam logic [1:0] SEL_Y2    = 2'b01;
  localparam logic [1:0] SEL_Y3    = 2'b10;
  localparam logic [1:0] SEL_FLAGS = 2'b11;

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [REC_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rdy_q, rdy_d;
  logic [1:0]       state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [1:0]       sel_q, sel_d;
  logic [31:0]      pay_q, pay_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      out_data_q, out_data_d;
  logic             out_last_q, out_last_d;

  logic             push;
  logic             pop;
  logic             xfer;
  logic             frame_done;
  logic [REC_W-1:0] in_rec;
  logic [REC_W-1:0] head;
  logic [31:0]      in_pay;

  // Records are stored pre-compacted: only the payload that will actually be sent is kept.
  always_comb begin
    in_pay = 32'h0;
    case (in_sel)
      SEL_Y1:    in_pay = {16'h0, in_y1};
      SEL_Y2:    in_pay = in_y2;
      SEL_Y3:    in_pay = {16'h0, in_y3};
      default:   in_pay = 32'h0;
    endcase
    in_rec = {in_sel, in_cout, in_carry_out, in_m, in_pay};
  end

  assign push       = in_valid && rdy_q;
  assign xfer       = out_valid_q && out_ready;
  assign frame_done = xfer && out_last_q;
  assign head       = mem_q[rd_q];
  assign pop        = (cnt_q != '0) && ((state_q == ST_IDLE) || frame_done);

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_q] = in_rec;
    end
    wr_d  = wr_q + PW'(push);
    rd_d  = rd_q + PW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    rdy_d = (cnt_d != FULL);
  end

  // Sequence number advances on the header handshake, so a header loaded on that
  // same edge (back-to-back after a header-only frame) must already carry the new value.
  always_comb begin
    seq_d       = seq_q + SEQ_W'(xfer && (state_q == ST_HDR));
    state_d     = state_q;
    sel_d       = sel_q;
    pay_d       = pay_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (pop) begin
      state_d     = ST_HDR;
      sel_d       = head[36:35];
      pay_d       = head[31:0];
      out_valid_d = 1'b1;
      out_data_d  = {head[36:35], head[34], head[33], head[32], 3'b000, seq_d};
      out_last_d  = (head[36:35] == SEL_FLAGS);
    end else if (frame_done) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      out_data_d  = 16'h0;
      out_last_d  = 1'b0;
    end else if (xfer) begin
      case (state_q)
        ST_HDR: begin
          state_d    = ST_PAY0;
          out_data_d = (sel_q == SEL_Y2) ? pay_q[31:16] : pay_q[15:0];
          out_last_d = (sel_q != SEL_Y2);
        end
        ST_PAY0: begin
          state_d    = ST_PAY1;
          out_data_d = pay_q[15:0];
          out_last_d = 1'b1;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      rdy_q       <= 1'b0;
      state_q     <= ST_IDLE;
      seq_q       <= '0;
      sel_q       <= 2'b00;
      pay_q       <= 32'h0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0;
      out_last_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      rdy_q       <= rdy_d;
      state_q     <= state_d;
      seq_q       <= seq_d;
      sel_q       <= sel_d;
      pay_q       <= pay_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign rec_count = cnt_q;
  assign busy      = (cnt_q != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_result_packer.sv
// Self-checking bench for alu_result_packer: directed frames plus randomized records,
// compared against a queue of expected words built from the frame format.
module tb_alu_result_packer;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_sel;
   logic [15:0] in_y1;
   logic [31:0] in_y2;
   logic [15:0] in_y3;
   logic        in_cout;
   logic        in_carry_out;
   logic        in_m;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_last;
   logic [$clog2(DEPTH):0] rec_count;
   logic        busy;

   int          tests;
   int          fails;
   logic [16:0] expq[$];
   logic [7:0]  mseq;
   logic        accepted;
   logic        randReady;

   alu_result_packer #(.DEPTH(DEPTH), .SEQ_W(8)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_sel(in_sel),
      .in_y1(in_y1),
      .in_y2(in_y2),
      .in_y3(in_y3),
      .in_cout(in_cout),
      .in_carry_out(in_carry_out),
      .in_m(in_m),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_last(out_last),
      .rec_count(rec_count),
      .busy(busy)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends even if the stimulus gets stuck.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference model: an accepted record becomes its complete list of words, in order.
   task automatic modelPush();
      logic [15:0] hdr;
      hdr = {in_sel, in_cout, in_carry_out, in_m, 3'b000, mseq};
      mseq = mseq + 8'd1;
      expq.push_back({(in_sel == 2'b11), hdr});
      case (in_sel)
         2'b00: expq.push_back({1'b1, in_y1});
         2'b01: begin
            expq.push_back({1'b0, in_y2[31:16]});
            expq.push_back({1'b1, in_y2[15:0]});
         end
         2'b10: expq.push_back({1'b1, in_y3});
         default: ;
      endcase
   endtask

   // One clock cycle, entered and left at a falling edge: check the word on offer,
   // account for both handshakes, then advance.
   task automatic applyStimulus();
      logic pushedNow;
      pushedNow = 1'b0;
      if (out_valid) begin
         if (expq.size() == 0) begin
            checkOutput("spurious_valid", {31'b0, out_valid}, 32'd0);
         end else begin
            checkOutput("word", {15'b0, out_last, out_data}, {15'b0, expq[0]});
            if (out_ready) void'(expq.pop_front());
         end
      end
      if (in_valid && in_ready) begin
         modelPush();
         accepted  = 1'b1;
         pushedNow = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      if (pushedNow) begin
         in_valid = 1'b0;
         in_y1    = 16'($urandom);
         in_y2    = $urandom;
         in_y3    = 16'($urandom);
      end
      if (randReady) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic sendRecord(input logic [1:0] sel, input logic [15:0] y1, input logic [31:0] y2,
                             input logic [15:0] y3, input logic c, input logic cy, input logic m);
      in_sel       = sel;
      in_y1        = y1;
      in_y2        = y2;
      in_y3        = y3;
      in_cout      = c;
      in_carry_out = cy;
      in_m         = m;
      in_valid     = 1'b1;
      accepted     = 1'b0;
      for (int i = 0; i < 500 && !accepted; i++) applyStimulus();
      if (!accepted) checkOutput("send_timeout", {31'b0, accepted}, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic sendRandom();
      sendRecord(2'($urandom), 16'($urandom), $urandom, 16'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom));
   endtask

   task automatic drain();
      for (int i = 0; i < 2000 && (expq.size() != 0 || out_valid); i++) applyStimulus();
      checkOutput("drain_left", expq.size(), 32'd0);
   endtask

   task automatic doReset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      expq.delete();
      mseq = 8'd0;
      @(negedge clk);
   endtask

   initial begin
      tests = 0; fails = 0; mseq = 8'd0; accepted = 1'b0; randReady = 1'b0;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_sel = 2'b00; in_y1 = 16'h0; in_y2 = 32'h0; in_y3 = 16'h0;
      in_cout = 1'b0; in_carry_out = 1'b0; in_m = 1'b0;

      // Reset state while rst is held.
      repeat (2) @(negedge clk);
      checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("rst_out_data", {16'b0, out_data}, 32'd0);
      checkOutput("rst_out_last", {31'b0, out_last}, 32'd0);
      checkOutput("rst_rec_count", {29'b0, rec_count}, 32'd0);
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("release_in_ready", {31'b0, in_ready}, 32'd1);

      // T1: sel=00, one-cycle latency from push to header.
      out_ready = 1'b1;
      sendRecord(2'b00, 16'h001E, $urandom, 16'($urandom), 1'b0, 1'b0, 1'b0);
      checkOutput("t1_latency_idle", {31'b0, out_valid}, 32'd0);
      checkOutput("t1_busy", {31'b0, busy}, 32'd1);
      applyStimulus();
      checkOutput("t1_hdr", {15'b0, out_valid, out_last, out_data}, {15'b0, 1'b1, 1'b0, 16'h0000});
      drain();

      // T2: sel=01 with seq 1.
      sendRecord(2'b01, 16'($urandom), 32'h0000_0113, 16'($urandom), 1'b0, 1'b0, 1'b0);
      applyStimulus();
      checkOutput("t2_hdr", {15'b0, out_last, out_data}, {15'b0, 1'b0, 16'h4001});
      drain();

      // T3: flags-only frame, header is also last.
      sendRecord(2'b11, 16'($urandom), $urandom, 16'($urandom), 1'b1, 1'b0, 1'b1);
      applyStimulus();
      checkOutput("t3_hdr", {15'b0, out_last, out_data}, {15'b0, 1'b1, 16'hE802});
      drain();
      checkOutput("t3_idle_busy", {31'b0, busy}, 32'd0);

      // T4: fill under backpressure; one record sits in the framer, DEPTH in the FIFO.
      out_ready = 1'b0;
      for (int k = 0; k < DEPTH + 1; k++) sendRandom();
      checkOutput("t4_full_count", {29'b0, rec_count}, DEPTH);
      checkOutput("t4_full_ready", {31'b0, in_ready}, 32'd0);
      in_sel = 2'b01; in_y2 = $urandom; in_cout = 1'b1; in_carry_out = 1'b1; in_m = 1'b0;
      in_valid = 1'b1;
      accepted = 1'b0;
      repeat (5) applyStimulus();
      checkOutput("t4_held_off", {31'b0, accepted}, 32'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 200 && expq.size() != 0; i++) begin
         checkOutput("t4_gapless", {31'b0, out_valid}, 32'd1);
         applyStimulus();
      end
      in_valid = 1'b0;
      checkOutput("t4_held_taken", {31'b0, accepted}, 32'd1);
      drain();

      // Randomized records, gaps and backpressure.
      randReady = 1'b1;
      for (int k = 0; k < 60; k++) begin
         sendRandom();
         repeat ($urandom_range(0, 2)) applyStimulus();
      end
      randReady = 1'b0;
      out_ready = 1'b1;
      drain();
      checkOutput("rand_count", {29'b0, rec_count}, 32'd0);
      checkOutput("rand_busy", {31'b0, busy}, 32'd0);

      // T6: reset during PAY0 of a sel=01 frame with another record queued.
      out_ready = 1'b0;
      sendRecord(2'b01, 16'($urandom), 32'hA5A5_5A5A, 16'($urandom), 1'b0, 1'b1, 1'b0);
      sendRandom();
      for (int i = 0; i < 20 && !out_valid; i++) applyStimulus();
      out_ready = 1'b1;
      applyStimulus();
      out_ready = 1'b0;
      checkOutput("t6_pay0", {15'b0, out_valid, out_data}, {15'b0, 1'b1, 16'hA5A5});
      rst = 1'b1;
      #1;
      checkOutput("t6_rst_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("t6_rst_count", {29'b0, rec_count}, 32'd0);
      checkOutput("t6_rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("t6_rst_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      expq.delete();
      mseq = 8'd0;
      @(negedge clk);
      checkOutput("t6_post_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("t6_post_ready", {31'b0, in_ready}, 32'd1);
      out_ready = 1'b1;
      sendRecord(2'b10, 16'($urandom), $urandom, 16'h1234, 1'b0, 1'b0, 1'b0);
      applyStimulus();
      checkOutput("t6_seq0_hdr", {15'b0, out_last, out_data}, {15'b0, 1'b0, 16'h8000});
      drain();

      // T5: 257 sel=10 records from seq 0; the model covers the 255 -> 0 wrap.
      doReset();
      out_ready = 1'b1;
      for (int k = 0; k < 257; k++) begin
         sendRecord(2'b10, 16'($urandom), $urandom, 16'(k), 1'b0, 1'b0, 1'b0);
      end
      checkOutput("t5_model_seq", {24'b0, mseq}, 32'd1);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
